// File: rtl/fifo_buffer.sv
// Single-clock FIFO with occupancy flags and sticky overflow/underflow error.
// Flags decode the registered count only, never the current push/pop.
module fifo_buffer #(
    parameter int DATA_WIDTH      = 10,
    parameter int ADDR_WIDTH      = 3,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_TH = ALMOST_FULL_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_TH = ALMOST_EMPTY_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] ONE_C = 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  error_q, error_d;

    logic push_ok;
    logic pop_ok;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_TH);
    assign almost_empty = (count_q <= AE_TH);
    assign fill_level   = count_q;
    assign data_out     = data_out_q;
    assign valid_out    = valid_out_q;
    assign error        = error_q;

    // A pop frees a slot in the same cycle, so push is allowed at full with pop.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        error_d     = error_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            data_out_d  = mem_q[rd_ptr_q];
            valid_out_d = 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        if ((push && full && !pop_ok) || (pop && empty)) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            error_q     <= error_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_fifo_buffer.sv
// Bench for fifo_buffer: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_fifo_buffer;

    localparam int DW    = 10;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk;
    logic          reset;
    logic          push;
    logic [DW-1:0] data_in;
    logic          pop;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   fill_level;
    logic          error;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_valid;
    logic          m_err;

    fifo_buffer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .ALMOST_FULL_TH(AF),
        .ALMOST_EMPTY_TH(AE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .push(push),
        .data_in(data_in),
        .pop(pop),
        .data_out(data_out),
        .valid_out(valid_out),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .fill_level(fill_level),
        .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
        chk({tag, ".valid_out"}, 32'(valid_out), 32'(m_valid));
        chk({tag, ".fill_level"}, 32'(fill_level), 32'(n));
        chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AF));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
        chk({tag, ".error"}, 32'(error), 32'(m_err));
    endtask

    // One clock: apply inputs, advance model at the edge, check 1ns later.
    task automatic step(input string tag, input logic p, input logic [DW-1:0] d,
                        input logic r);
        bit was_full;
        bit was_empty;
        bit pop_ok;
        bit push_ok;
        push    = p;
        data_in = d;
        pop     = r;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        pop_ok    = r && !was_empty;
        push_ok   = p && (!was_full || pop_ok);
        m_valid   = pop_ok;
        if (pop_ok) m_dout = q.pop_front();
        if (push_ok) q.push_back(d);
        if ((r && was_empty) || (p && was_full && !pop_ok)) m_err = 1'b1;
        #1;
        check_all(tag);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic mid_reset(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all({tag, ".async"});
        @(posedge clk);
        #3;
        reset = 1'b0;
        check_all({tag, ".held"});
    endtask

    initial begin
        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Underflow straight out of reset.
        step("underflow", 1'b0, '0, 1'b1);
        mid_reset("clr0");

        // Fill and drain.
        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, DW'(i), 1'b0);
        chk("fill.full_lit", 32'(full), 32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            step("drain", 1'b0, '0, 1'b1);
            chk("drain.order", 32'(data_out), 32'(i));
        end

        // Wrap-around.
        for (int i = 0; i < 5; i++) step("wrap.p1", 1'b1, DW'(i + 'h40), 1'b0);
        for (int i = 0; i < 5; i++) step("wrap.d1", 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) step("wrap.p2", 1'b1, DW'('h2AA + i), 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("wrap.d2", 1'b0, '0, 1'b1);
            chk("wrap.word", 32'(data_out), 32'('h2AA + i));
        end
        chk("wrap.error", 32'(error), 32'd0);

        // Simultaneous push/pop at full.
        for (int i = 0; i < DEPTH; i++) step("sim.fill", 1'b1, DW'('h80 + i), 1'b0);
        step("sim.full", 1'b1, 10'h155, 1'b1);
        chk("sim.full.oldest", 32'(data_out), 32'h80);
        for (int i = 0; i < DEPTH; i++) step("sim.drain", 1'b0, '0, 1'b1);
        chk("sim.full.last", 32'(data_out), 32'h155);

        // Simultaneous push/pop at empty.
        step("sim.empty", 1'b1, 10'h0F0, 1'b1);
        step("sim.empty.pop", 1'b0, '0, 1'b1);
        chk("sim.empty.word", 32'(data_out), 32'h0F0);

        // Overflow.
        mid_reset("clr1");
        for (int i = 0; i < DEPTH; i++) step("ovf.fill", 1'b1, DW'('h10 + i), 1'b0);
        step("ovf.push", 1'b1, 10'h3FF, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step("ovf.drain", 1'b0, '0, 1'b1);
            chk("ovf.word", 32'(data_out), 32'('h10 + i));
        end

        // Reset with data stored, then reuse.
        for (int i = 0; i < 4; i++) step("rst.fill", 1'b1, DW'('h200 + i), 1'b0);
        mid_reset("rst.mid");
        step("rst.push", 1'b1, 10'h123, 1'b0);
        step("rst.pop", 1'b0, '0, 1'b1);
        chk("rst.word", 32'(data_out), 32'h123);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) mid_reset("rnd.rst");
            step("rnd", 1'($urandom_range(0, 1)), DW'($urandom),
                 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_buffer.md
# fifo_buffer

Synchronous single-clock FIFO holding the 10-bit words exchanged around the round-robin arbiter. One instance sits on each of the four input ports, where the arbiter consumes `empty` and drives `pop`. Another instance sits on each of the four output ports, where the arbiter consumes `almost_full` and drives `push`. The block provides storage, occupancy tracking, threshold flags and sticky overflow/underflow detection.

## Interface
- `DATA_WIDTH`, 10, word width.
- `ADDR_WIDTH`, 3, pointer width; depth = 2^ADDR_WIDTH (8).
- `ALMOST_FULL_TH`, 6, `almost_full` asserts when count >= this value.
- `ALMOST_EMPTY_TH`, 2, `almost_empty` asserts when count <= this value.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `push`  in  1  write request.
- `data_in`  in  DATA_WIDTH  write word, sampled on the edge where `push` is accepted.
- `pop`  in  1  read request.
- `data_out`  out  DATA_WIDTH  registered read word.
- `valid_out`  out  1  high for the one cycle after an accepted pop.
- `full`  out  1  count == depth.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count >= ALMOST_FULL_TH.
- `almost_empty`  out  1  count <= ALMOST_EMPTY_TH.
- `fill_level`  out  ADDR_WIDTH+1  current count, 0..depth.
- `error`  out  1  sticky overflow/underflow flag.

## Operation
- Storage: array of depth words, write pointer `wr_ptr`, read pointer `rd_ptr`, counter `count` of ADDR_WIDTH+1 bits.
- Pointers wrap modulo depth; 7 -> 0 at default parameters.
- Memory contents are not cleared by reset.
- Push is accepted when `push` && (!full || pop accepted in the same cycle).
  - On accept: mem[wr_ptr] <= data_in, wr_ptr increments.
- Pop is accepted when `pop` && !empty.
  - On accept: data_out <= mem[rd_ptr], rd_ptr increments, valid_out <= 1.
  - Otherwise valid_out <= 0 and data_out holds its value.
- Count update per edge:
  - push only: +1.
  - pop only: −1.
  - both, or neither: unchanged.
- Simultaneous push and pop:
  - When full: both are accepted. The read returns the old word at rd_ptr; the write lands in the same slot. Count stays at depth.
  - When empty: the push is accepted, the pop is rejected (no bypass), and `error` sets. Count becomes 1.
- Overflow: push while full without pop. The write is dropped, pointers and count are unchanged, `error` sets.
- Underflow: pop while empty. No read occurs, valid_out stays 0, `error` sets.
- `error` is sticky until reset.
- Flags and `fill_level` are combinational decodes of the registered `count`. They therefore reflect state after the most recent edge and never depend combinationally on `push`/`pop`.
- Reset values, applied immediately on reset assertion regardless of clk:
  - wr_ptr = rd_ptr = count = 0.
  - data_out = 0, valid_out = 0, error = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0, fill_level = 0.
- Reset mid-operation discards all stored words. The first push after deassertion writes slot 0.

## Timing
- Push accepted at edge N: `empty` falls and `fill_level` increments after edge N. The word is poppable at edge N+1.
- Pop accepted at edge M: `data_out`/`valid_out` update after edge M, i.e. one-cycle read latency. `empty`/`almost_empty` update after edge M.
- Minimum push-to-data_out latency is 2 edges.
- Throughput is one push and one pop per cycle sustained.
- `almost_full` is early warning only. The upstream producer must stop pushing within depth − ALMOST_FULL_TH (2) cycles of seeing it to avoid overflow.
- Reset deassertion is sampled like a normal input. The first accepted operation is on the first rising edge after deassertion.

## Test plan
- Fill/drain: push 0x001..0x008 on 8 consecutive edges.
  - full = 1 and fill_level = 8 after the 8th push; almost_full rises after the 6th.
  - Then pop 8 times: data_out = 0x001..0x008 in order with valid_out = 1 each cycle, and empty = 1 at the end.
- Wrap-around: push 5 words, pop 5, push 0x2AA..0x2AE, pop 5.
  - data_out = 0x2AA..0x2AE; pointers crossed 7 -> 0 without corruption; error = 0.
- Overflow: fill to 8, push 0x3FF with no pop.
  - fill_level stays 8, error = 1 next cycle, and draining returns the original 8 words with no 0x3FF.
- Underflow: from reset, assert pop for 1 cycle.
  - valid_out = 0, data_out = 0, error = 1, empty stays 1.
- Simultaneous ops:
  - At full, push 0x155 with pop: data_out = oldest word, fill_level = 8, error = 0.
  - At empty, push 0x0F0 with pop: fill_level = 1, valid_out = 0, error = 1.
  - Then pop: data_out = 0x0F0.
- Reset mid-operation: with 4 words stored, assert reset between clock edges.
  - All outputs take reset values immediately.
  - After release, push 0x123 then pop: data_out = 0x123.
